mul_div_sequencer: RTL

MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

---
 rtl/mul_div_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mul_div_sequencer.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per cycle.
// Latency XLEN+1 edges (2 edges for divide-by-zero/overflow); stall holds the pipeline, flush aborts.
module mul_div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  localparam int CW = $clog2(XLEN);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic              neg_q;
  logic              spec_q;

  // operand decode at acceptance
  logic            is_div, a_sgn, b_sgn, neg, div0, ovf;
  logic [XLEN-1:0] a_abs, b_abs, spec_val;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = op_a[XLEN-1] & (is_div ? ~funct3[0] : (funct3[1:0] != 2'b11));
    b_sgn    = op_b[XLEN-1] & (is_div ? ~funct3[0] : ~funct3[1]);
    a_abs    = a_sgn ? -op_a : op_a;
    b_abs    = b_sgn ? -op_b : op_b;
    neg      = (is_div && funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
    div0     = is_div && (op_b == '0);
    ovf      = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    spec_val = '0;
    if (div0)
      spec_val = funct3[1] ? op_a : '1;
    else if (ovf)
      spec_val = funct3[1] ? '0 : op_a;
  end

  // one iteration step; acc holds {hi/remainder, lo/multiplier-or-quotient}
  logic [XLEN:0]     mul_sum, shifted, diff;
  logic              qbit;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = shifted - {1'b0, opnd};
    qbit     = ~diff[XLEN];
    div_next = {(qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0]), acc[XLEN-2:0], qbit};
  end

  // sign correction and result select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_val;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (spec_q)
      fin_val = acc[XLEN-1:0];
    else if (f3_q[2])
      fin_val = f3_q[1] ? rem_fix : quo_fix;
    else
      fin_val = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      f3_q   <= '0;
      opnd   <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            f3_q   <= funct3;
            cnt    <= '0;
            neg_q  <= neg;
            opnd   <= b_abs;
            spec_q <= div0 | ovf;
            acc    <= (div0 | ovf) ? {{XLEN{1'b0}}, spec_val} : {{XLEN{1'b0}}, a_abs};
            state  <= CALC;
          end
          // special cases spend a single cycle here without iterating
          CALC: begin
            if (spec_q) begin
              state <= FIN;
            end else begin
              acc <= f3_q[2] ? div_next : mul_next;
              cnt <= cnt + CW'(1);
              if (cnt == CW'(XLEN-1))
                state <= FIN;
            end
          end
          FIN: begin
            result <= fin_val;
            done   <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy  = (state != IDLE);
  assign stall = ((state == IDLE) && start && !flush) || (state == CALC);

endmodule
